apb_slave_regs: RTL and testbench

APB_SLAVE_REGS -- requirements
Module: apb_slave_regs

---
 rtl/apb_pkg.sv | 13 +
 rtl/apb_slave_regs_if.sv | 25 ++
 rtl/apb_regfile.sv | 29 ++
 rtl/apb_slave_regs.sv | 122 ++++++++++++
 tb/tb_apb_slave_regs.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_pkg.sv
// Shared definitions for the APB register slave: FSM encoding, ID word, counter width.
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_DONE   = 2'b10
  } state_e;

  localparam logic [31:0] ID_VALUE = 32'hA5B0_0001;
  localparam int unsigned CNT_W    = 3;

endpackage

// File: rtl/apb_slave_regs_if.sv
// APB bus bundle between one master and the register slave.
interface apb_slave_regs_if #(
  parameter int unsigned WIDTH = 32
);

  logic             PSEL;
  logic             PENABLE;
  logic             PWRITE;
  logic [WIDTH:0]   PADDR;
  logic [WIDTH-1:0] PWDATA;
  logic             PREADY;
  logic [WIDTH-1:0] PRDATA;
  logic             PSLVERR;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PREADY, PRDATA, PSLVERR
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PREADY, PRDATA, PSLVERR
  );

endinterface

// File: rtl/apb_regfile.sv
// Word register storage: one synchronous write port, one combinational read port.
module apb_regfile #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Storage update; reset clears every word and wins over a pending write.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mem_q <= '{default: '0};
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/apb_slave_regs.sv
// APB slave with DEPTH word registers, read-only ID at index 0 and programmable wait states.
module apb_slave_regs
  import apb_pkg::*;
#(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned WAIT_STATES = 2
) (
  input  logic            PCLK,
  input  logic            PRESETn,
  apb_slave_regs_if.slave apb
);

  localparam int unsigned AW = $clog2(DEPTH);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic             write_q, write_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic             err_q, err_d;

  logic             setup_c;
  logic             addr_err_c;
  logic [AW-1:0]    sel_idx_c;
  logic             pready_c;
  logic             we_c;
  logic [WIDTH-1:0] rf_rdata_c;
  logic [WIDTH-1:0] rd_word_c;
  logic             unused_sel_bit_c;

  // The top address bit selects this slave at the master and carries no meaning here.
  assign unused_sel_bit_c = apb.PADDR[WIDTH];

  // Decode of the live bus address, only meaningful in the setup phase.
  assign setup_c    = apb.PSEL && !apb.PENABLE;
  assign sel_idx_c  = apb.PADDR[AW+1:2];
  assign addr_err_c = (apb.PADDR[1:0] != 2'b00)
                   || (|apb.PADDR[WIDTH-1:AW+2])
                   || (apb.PWRITE && (sel_idx_c == '0));

  // State and holding registers.
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state, transfer capture, wait counting and completion strobe.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    write_d  = write_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    pready_c = 1'b0;
    we_c     = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (setup_c) begin
          idx_d   = sel_idx_c;
          write_d = apb.PWRITE;
          wdata_d = apb.PWDATA;
          err_d   = addr_err_c;
          cnt_d   = CNT_W'(WAIT_STATES);
          state_d = ST_ACCESS;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (!apb.PSEL) begin
          state_d = ST_IDLE;
        end else if (apb.PENABLE) begin
          if (cnt_q == '0) begin
            pready_c = 1'b1;
            we_c     = write_q && !err_q;
            state_d  = ST_DONE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  apb_regfile #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_regfile (
    .clk_i   (PCLK),
    .rst_ni  (PRESETn),
    .we_i    (we_c),
    .waddr_i (idx_q),
    .wdata_i (wdata_q),
    .raddr_i (idx_q),
    .rdata_o (rf_rdata_c)
  );

  // Response: data only on a good read completion, error only alongside PREADY.
  assign rd_word_c   = (idx_q == '0) ? WIDTH'(ID_VALUE) : rf_rdata_c;
  assign apb.PREADY  = pready_c;
  assign apb.PSLVERR = pready_c && err_q;
  assign apb.PRDATA  = (pready_c && !write_q && !err_q) ? rd_word_c : '0;

endmodule

// File: tb/tb_apb_slave_regs.sv
// Self-checking bench: two slaves (2 and 0 wait states), directed table, corner sequences, random traffic.
module tb_apb_slave_regs;

  localparam logic [31:0] ID_WORD = 32'hA5B0_0001;

  logic        PCLK;
  logic        PRESETn;
  logic        psel2, psel0, penable, pwrite;
  logic [32:0] paddr;
  logic [31:0] pwdata;

  logic        pready2, pslverr2, pready0, pslverr0;
  logic [31:0] prdata2, prdata0;

  int tests  = 0;
  int failed = 0;

  logic [31:0] m2 [16];
  logic [31:0] m0 [16];

  apb_slave_regs_if #(.WIDTH(32)) if2 ();
  apb_slave_regs_if #(.WIDTH(32)) if0 ();

  assign if2.PSEL    = psel2;
  assign if2.PENABLE = penable;
  assign if2.PWRITE  = pwrite;
  assign if2.PADDR   = paddr;
  assign if2.PWDATA  = pwdata;
  assign if0.PSEL    = psel0;
  assign if0.PENABLE = penable;
  assign if0.PWRITE  = pwrite;
  assign if0.PADDR   = paddr;
  assign if0.PWDATA  = pwdata;
  assign pready2     = if2.PREADY;
  assign pslverr2    = if2.PSLVERR;
  assign prdata2     = if2.PRDATA;
  assign pready0     = if0.PREADY;
  assign pslverr0    = if0.PSLVERR;
  assign prdata0     = if0.PRDATA;

  apb_slave_regs #(.WIDTH(32), .DEPTH(16), .WAIT_STATES(2)) dut2 (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .apb     (if2)
  );

  apb_slave_regs #(.WIDTH(32), .DEPTH(16), .WAIT_STATES(0)) dut0 (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .apb     (if0)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  typedef struct {
    bit          wr;
    logic [32:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    bit          exp_err;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Reference rules: a word-aligned address inside DEPTH*4 bytes, never writing word 0.
  function automatic bit model_err(input bit wr, input logic [32:0] a);
    return (a[31:0] % 4 != 0) || (a[31:0] >= 32'd64) || (wr && a[31:0] < 32'd4);
  endfunction

  function automatic logic [31:0] model_read(input int which, input logic [32:0] a);
    if (a[5:2] == 4'd0) return ID_WORD;
    return (which == 2) ? m2[a[5:2]] : m0[a[5:2]];
  endfunction

  task automatic model_write(input int which, input bit wr, input logic [32:0] a, input logic [31:0] wd);
    if (wr && !model_err(wr, a)) begin
      if (which == 2) m2[a[5:2]] = wd;
      else            m0[a[5:2]] = wd;
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      m2[i] = '0;
      m0[i] = '0;
    end
  endtask

  // One APB transfer; entered and left 1 time unit after a rising edge.
  task automatic xfer(input int which, input bit wr, input logic [32:0] a, input logic [31:0] wd,
                      input int stall, input bit scramble,
                      output logic [31:0] rd, output bit err, output int waits, output bit ok);
    logic rdy, serr;
    logic [31:0] rdat;
    if (which == 2) psel2 = 1'b1; else psel0 = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = a;
    pwdata  = wd;
    @(posedge PCLK); #1;
    for (int s = 0; s < stall; s++) begin
      @(posedge PCLK); #1;
    end
    penable = 1'b1;
    if (scramble) begin
      paddr  = {1'($urandom), $urandom};
      pwdata = $urandom;
      pwrite = 1'($urandom);
    end
    waits = 0;
    ok    = 1'b0;
    rd    = '0;
    err   = 1'b0;
    while (!ok && waits <= 32) begin
      @(negedge PCLK);
      rdy  = (which == 2) ? pready2  : pready0;
      serr = (which == 2) ? pslverr2 : pslverr0;
      rdat = (which == 2) ? prdata2  : prdata0;
      if (rdy) begin
        ok  = 1'b1;
        rd  = rdat;
        err = serr;
      end else begin
        check("pslverr_while_waiting", 32'(serr), 32'd0);
        waits++;
      end
      @(posedge PCLK); #1;
    end
    psel2   = 1'b0;
    psel0   = 1'b0;
    penable = 1'b0;
  endtask

  logic [31:0] rd;
  bit          err, ok;
  int          waits;

  initial begin
    PRESETn = 1'b0;
    psel2   = 1'b0;
    psel0   = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = '0;
    pwdata  = '0;
    model_clear();

    vecs[0]  = '{1'b1, 33'h0_0000_0008, 32'h1234_5678, 32'h0,         1'b0};
    vecs[1]  = '{1'b0, 33'h0_0000_0008, 32'h0,         32'h1234_5678, 1'b0};
    vecs[2]  = '{1'b0, 33'h0_0000_0000, 32'h0,         32'hA5B0_0001, 1'b0};
    vecs[3]  = '{1'b1, 33'h0_0000_0000, 32'hFFFF_FFFF, 32'h0,         1'b1};
    vecs[4]  = '{1'b0, 33'h0_0000_0000, 32'h0,         32'hA5B0_0001, 1'b0};
    vecs[5]  = '{1'b1, 33'h0_0000_0006, 32'h0BAD_F00D, 32'h0,         1'b1};
    vecs[6]  = '{1'b1, 33'h0_0000_0040, 32'h0BAD_F00D, 32'h0,         1'b1};
    vecs[7]  = '{1'b0, 33'h0_0000_0008, 32'h0,         32'h1234_5678, 1'b0};
    vecs[8]  = '{1'b0, 33'h0_0000_0004, 32'h0,         32'h0,         1'b0};
    vecs[9]  = '{1'b1, 33'h0_0000_0010, 32'h0000_1111, 32'h0,         1'b0};
    vecs[10] = '{1'b0, 33'h0_0000_0010, 32'h0,         32'h0000_1111, 1'b0};
    vecs[11] = '{1'b1, 33'h1_0000_0014, 32'hCAFE_F00D, 32'h0,         1'b0};
    vecs[12] = '{1'b0, 33'h0_0000_0014, 32'h0,         32'hCAFE_F00D, 1'b0};

    // Reset state
    repeat (3) @(posedge PCLK);
    #1;
    check("rst_pready2",  32'(pready2),  32'd0);
    check("rst_pslverr2", 32'(pslverr2), 32'd0);
    check("rst_prdata2",  prdata2,       32'd0);
    check("rst_pready0",  32'(pready0),  32'd0);
    check("rst_pslverr0", 32'(pslverr0), 32'd0);
    check("rst_prdata0",  prdata0,       32'd0);
    PRESETn = 1'b1;
    @(posedge PCLK); #1;

    // Directed table on the two-wait-state slave
    for (int i = 0; i < 13; i++) begin
      xfer(2, vecs[i].wr, vecs[i].addr, vecs[i].wdata, 0, 1'b0, rd, err, waits, ok);
      check($sformatf("vec%0d_done", i),  32'(ok),    32'd1);
      check($sformatf("vec%0d_err", i),   32'(err),   32'(vecs[i].exp_err));
      check($sformatf("vec%0d_waits", i), 32'(waits), 32'd2);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].wr ? 32'h0 : vecs[i].exp_rd);
      model_write(2, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
    end

    // Counter holds while PENABLE is low in the access phase
    xfer(2, 1'b0, 33'h0_0000_0008, 32'h0, 3, 1'b0, rd, err, waits, ok);
    check("stall_waits", 32'(waits), 32'd2);
    check("stall_rdata", rd, 32'h1234_5678);

    // Zero-wait back-to-back writes then reads
    xfer(0, 1'b1, 33'h0_0000_0004, 32'h1111_1111, 0, 1'b0, rd, err, waits, ok);
    check("b2b_w1_waits", 32'(waits), 32'd0);
    xfer(0, 1'b1, 33'h0_0000_0008, 32'h2222_2222, 0, 1'b0, rd, err, waits, ok);
    check("b2b_w2_waits", 32'(waits), 32'd0);
    xfer(0, 1'b1, 33'h0_0000_000C, 32'h3333_3333, 0, 1'b0, rd, err, waits, ok);
    check("b2b_w3_waits", 32'(waits), 32'd0);
    check("b2b_w3_err",   32'(err),   32'd0);
    m0[1] = 32'h1111_1111;
    m0[2] = 32'h2222_2222;
    m0[3] = 32'h3333_3333;
    xfer(0, 1'b0, 33'h0_0000_0004, 32'h0, 0, 1'b0, rd, err, waits, ok);
    check("b2b_r1", rd, 32'h1111_1111);
    xfer(0, 1'b0, 33'h0_0000_0008, 32'h0, 0, 1'b0, rd, err, waits, ok);
    check("b2b_r2", rd, 32'h2222_2222);
    xfer(0, 1'b0, 33'h0_0000_000C, 32'h0, 0, 1'b0, rd, err, waits, ok);
    check("b2b_r3", rd, 32'h3333_3333);
    check("b2b_r3_waits", 32'(waits), 32'd0);

    // Abort: PSEL drops after one access cycle of a write
    psel2 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 33'h0_0000_0010; pwdata = 32'hDEAD_BEEF;
    @(posedge PCLK); #1;
    penable = 1'b1;
    @(negedge PCLK);
    check("abort_ready_a", 32'(pready2), 32'd0);
    @(posedge PCLK); #1;
    psel2 = 1'b0; penable = 1'b0;
    @(negedge PCLK);
    check("abort_ready_b", 32'(pready2), 32'd0);
    @(posedge PCLK); #1;
    xfer(2, 1'b0, 33'h0_0000_0010, 32'h0, 0, 1'b0, rd, err, waits, ok);
    check("abort_readback", rd, 32'h0000_1111);

    // Random traffic on both slaves against the reference model
    for (int n = 0; n < 200; n++) begin
      int          which, r;
      bit          wr, exp_err;
      logic [31:0] lo, wd, exp_rd;
      logic [32:0] a;
      which = ($urandom_range(0, 1) == 1) ? 2 : 0;
      wr    = 1'($urandom);
      r     = int'($urandom_range(0, 9));
      lo    = {26'd0, 4'($urandom_range(1, 15)), 2'b00};
      if (r == 7) lo[1:0]  = 2'($urandom_range(1, 3));
      if (r == 8) lo[31:6] = 26'($urandom_range(1, 1000));
      if (r == 9) lo       = 32'h0;
      a       = {1'($urandom), lo};
      wd      = $urandom;
      exp_err = model_err(wr, a);
      exp_rd  = model_read(which, a);
      xfer(which, wr, a, wd, int'($urandom_range(0, 2)), 1'b1, rd, err, waits, ok);
      check("rnd_done",  32'(ok),    32'd1);
      check("rnd_err",   32'(err),   32'(exp_err));
      check("rnd_waits", 32'(waits), (which == 2) ? 32'd2 : 32'd0);
      if (wr) check("rnd_wr_rdata", rd, 32'h0);
      else if (!exp_err) check("rnd_rdata", rd, exp_rd);
      model_write(which, wr, a, wd);
    end

    // Reset in the middle of an access phase
    xfer(2, 1'b1, 33'h0_0000_0004, 32'h0000_00AA, 0, 1'b0, rd, err, waits, ok);
    xfer(0, 1'b1, 33'h0_0000_0004, 32'h0000_00AA, 0, 1'b0, rd, err, waits, ok);
    psel2 = 1'b1; psel0 = 1'b1; penable = 1'b0; pwrite = 1'b1;
    paddr = 33'h0_0000_0004; pwdata = 32'h0000_0055;
    @(posedge PCLK); #1;
    penable = 1'b1;
    PRESETn = 1'b0;
    @(posedge PCLK); #1;
    check("midrst_pready2",  32'(pready2),  32'd0);
    check("midrst_pslverr2", 32'(pslverr2), 32'd0);
    check("midrst_prdata2",  prdata2,       32'd0);
    check("midrst_pready0",  32'(pready0),  32'd0);
    check("midrst_prdata0",  prdata0,       32'd0);
    PRESETn = 1'b1; psel2 = 1'b0; psel0 = 1'b0; penable = 1'b0;
    model_clear();
    @(posedge PCLK); #1;
    xfer(2, 1'b0, 33'h0_0000_0004, 32'h0, 0, 1'b0, rd, err, waits, ok);
    check("midrst_read2", rd, 32'h0);
    xfer(0, 1'b0, 33'h0_0000_0004, 32'h0, 0, 1'b0, rd, err, waits, ok);
    check("midrst_read0", rd, 32'h0);
    xfer(0, 1'b0, 33'h0_0000_0000, 32'h0, 0, 1'b0, rd, err, waits, ok);
    check("midrst_id0", rd, ID_WORD);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
